// File: rtl/tt_check_pkg.sv
// rtl/tt_check_pkg.sv - shared types and constants for the truth table checker
package tt_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int N_IN_DEFAULT = 3;
    localparam int SETTLE_W     = 4;

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

    localparam int VEC_COUNT = vec_count(N_IN_DEFAULT);

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - down-counter that pulses expire after a loaded number of cycles
import tt_check_pkg::*;

module settle_timer (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] count,
    output logic                expire
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    // Reload on load, otherwise count down and rest at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = count;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last counted cycle; lets the FSM leave SETTLE after exactly count cycles
    assign expire = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - checks a gate's output against an expected truth table (option: TT_COVERAGE_EN)
import tt_check_pkg::*;

module truth_table_checker #(
    parameter int                         N_IN   = N_IN_DEFAULT,
    parameter logic [(1 << N_IN)-1:0]     EXP_TT = '0,
    parameter int                         SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            vec_valid,
    input  logic [N_IN-1:0] vec,
    output logic            vec_ready,
    input  logic            f_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
`ifdef TT_COVERAGE_EN
    output logic            cov_missing,
`endif
    output logic            first_err_valid
);

    localparam int                  NVEC       = vec_count(N_IN);
    localparam logic [N_IN:0]       NVEC_CNT   = (N_IN + 1)'(NVEC);
    localparam logic [SETTLE_W-1:0] SETTLE_CNT = SETTLE_W'(SETTLE);

    state_t              state_q, state_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [N_IN:0]       acc_q, acc_d;
    logic [N_IN:0]       err_q, err_d;
    logic [N_IN-1:0]     fev_q, fev_d;
    logic                fevv_q, fevv_d;
`ifdef TT_COVERAGE_EN
    logic [NVEC-1:0]     cov_q, cov_d;
`endif
    logic                timer_load;
    logic                timer_expire;

    settle_timer u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .count  (SETTLE_CNT),
        .expire (timer_expire)
    );

    // Next-state and result bookkeeping for one check run
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        acc_d      = acc_q;
        err_d      = err_q;
        fev_d      = fev_q;
        fevv_d     = fevv_q;
`ifdef TT_COVERAGE_EN
        cov_d      = cov_q;
`endif
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    acc_d   = '0;
                    err_d   = '0;
                    fev_d   = '0;
                    fevv_d  = 1'b0;
`ifdef TT_COVERAGE_EN
                    cov_d   = '0;
`endif
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (vec_valid) begin
                    vec_d      = vec;
                    timer_load = 1'b1;
`ifdef TT_COVERAGE_EN
                    cov_d[vec] = 1'b1;
`endif
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_expire) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (f_in != EXP_TT[vec_q]) begin
                    if (err_q != NVEC_CNT) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fevv_q) begin
                        fev_d  = vec_q;
                        fevv_d = 1'b1;
                    end
                end
                acc_d   = acc_q + 1'b1;
                state_d = (acc_d == NVEC_CNT) ? ST_DONE : ST_ARM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset abandons any run in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            acc_q   <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fevv_q  <= 1'b0;
`ifdef TT_COVERAGE_EN
            cov_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevv_q  <= fevv_d;
`ifdef TT_COVERAGE_EN
            cov_q   <= cov_d;
`endif
        end
    end

    assign vec_ready       = (state_q == ST_ARM);
    assign busy            = (state_q == ST_ARM) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done            = (state_q == ST_DONE);
    assign err_count       = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fevv_q;
`ifdef TT_COVERAGE_EN
    assign cov_missing     = (state_q == ST_DONE) && !(&cov_q);
    assign pass            = done && (err_q == '0) && !cov_missing;
`else
    assign pass            = done && (err_q == '0);
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - self-checking bench for truth_table_checker
module tb_truth_table_checker;
    import tt_check_pkg::*;

    localparam int         N      = 3;
    localparam int         NV     = VEC_COUNT;
    localparam logic [7:0] EXP    = 8'b1000_0000;
    localparam int         ST     = 3;
    localparam logic [7:0] AND_TT = 8'b1000_0000;
    localparam logic [7:0] OR_TT  = 8'b1111_1110;

    logic       clk = 1'b0;
    logic       rst, start, vec_valid, f_in;
    logic [2:0] vec;
    logic       vec_ready, busy, done, pass, first_err_valid;
    logic [3:0] err_count;
    logic [2:0] first_err_vec;
`ifdef TT_COVERAGE_EN
    logic       cov_missing;
`endif

    int applied     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    truth_table_checker #(.N_IN(N), .EXP_TT(EXP), .SETTLE(ST)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .vec_valid       (vec_valid),
        .vec             (vec),
        .vec_ready       (vec_ready),
        .f_in            (f_in),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_vec   (first_err_vec),
`ifdef TT_COVERAGE_EN
        .cov_missing     (cov_missing),
`endif
        .first_err_valid (first_err_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".vec_ready"}, 32'(vec_ready), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".pass"}, 32'(pass), 0);
        chk({tag, ".err_count"}, 32'(err_count), 0);
        chk({tag, ".first_err_vec"}, 32'(first_err_vec), 0);
        chk({tag, ".first_err_valid"}, 32'(first_err_valid), 0);
`ifdef TT_COVERAGE_EN
        chk({tag, ".cov_missing"}, 32'(cov_missing), 0);
`endif
    endtask

    task automatic wait_ready(input string tag);
        int c = 0;
        while (!vec_ready && c < 64) begin
            @(negedge clk);
            c++;
        end
        if (!vec_ready) chk({tag, ".ready_timeout"}, 32'(vec_ready), 1);
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!done && c < 64) begin
            @(negedge clk);
            c++;
        end
        if (!done) chk({tag, ".done_timeout"}, 32'(done), 1);
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".start_busy"}, 32'(busy), 1);
        chk({tag, ".start_done"}, 32'(done), 0);
        chk({tag, ".start_err"}, 32'(err_count), 0);
        chk({tag, ".start_fev"}, 32'(first_err_valid), 0);
    endtask

    // Gate under test is modelled by its truth table gtt; f_in held until the next vector
    task automatic apply_vec(input logic [2:0] v, input logic [7:0] gtt, input int gap);
        wait_ready("apply");
        repeat (gap) @(negedge clk);
        vec       = v;
        f_in      = gtt[v];
        vec_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vec_valid = 1'b0;
        applied++;
    endtask

    // Reference: count truth-table disagreements over the accepted vector list
    task automatic check_result(input string tag, input logic [7:0] gtt, input logic [2:0] vs [NV]);
        logic [7:0] exp_tt = EXP;
        int  e      = 0;
        int  fv     = 0;
        bit  fvalid = 0;
        bit  ep;
`ifdef TT_COVERAGE_EN
        bit  seen [NV];
        bit  miss = 0;
        for (int k = 0; k < NV; k++) seen[k] = 0;
        for (int i = 0; i < NV; i++) seen[vs[i]] = 1;
        for (int k = 0; k < NV; k++) if (!seen[k]) miss = 1;
`endif
        for (int i = 0; i < NV; i++) begin
            if (gtt[vs[i]] != exp_tt[vs[i]]) begin
                if (!fvalid) begin
                    fvalid = 1;
                    fv     = int'(vs[i]);
                end
                e++;
            end
        end
        if (e > NV) e = NV;
        ep = (e == 0);
`ifdef TT_COVERAGE_EN
        ep = ep && !miss;
        chk({tag, ".cov_missing"}, 32'(cov_missing), 32'(miss));
`endif
        chk({tag, ".done"}, 32'(done), 1);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".vec_ready"}, 32'(vec_ready), 0);
        chk({tag, ".err_count"}, 32'(err_count), 32'(e));
        chk({tag, ".first_err_valid"}, 32'(first_err_valid), 32'(fvalid));
        chk({tag, ".first_err_vec"}, 32'(first_err_vec), 32'(fvalid ? fv : 0));
        chk({tag, ".pass"}, 32'(pass), 32'(ep));
    endtask

    task automatic do_run(input string tag, input logic [7:0] gtt, input logic [2:0] vs [NV], input int maxgap);
        pulse_start(tag);
        for (int i = 0; i < NV; i++) apply_vec(vs[i], gtt, $urandom_range(0, maxgap));
        wait_done(tag);
        check_result(tag, gtt, vs);
    endtask

    initial begin
        logic [2:0] vs [NV];
        logic [7:0] rtt;

        rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec = '0; f_in = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Correct AND3 gate, vectors in order
        for (int i = 0; i < NV; i++) vs[i] = 3'(i);
        do_run("and_ok", AND_TT, vs, 2);
        chk("and_ok.pass_const", 32'(pass), 1);

        // OR3 gate against AND3 table
        do_run("or_bad", OR_TT, vs, 1);
        chk("or_bad.err_const", 32'(err_count), 6);
        chk("or_bad.fev_const", 32'(first_err_vec), 1);

        // Settle timing: mismatch on vector 1, sample visible SETTLE+1 edges after accept
        pulse_start("timing");
        wait_ready("timing");
        vec = 3'd1; f_in = OR_TT[1]; vec_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vec_valid = 1'b0;
        applied++;
        for (int j = 0; j <= ST; j++) begin
            chk($sformatf("timing.ready_low%0d", j), 32'(vec_ready), 0);
            chk($sformatf("timing.err_early%0d", j), 32'(err_count), 0);
            @(negedge clk);
        end
        chk("timing.ready_back", 32'(vec_ready), 1);
        chk("timing.err_sampled", 32'(err_count), 1);
        vs[0] = 3'd1; vs[1] = 3'd0;
        for (int i = 2; i < NV; i++) vs[i] = 3'(i);
        for (int i = 1; i < NV; i++) apply_vec(vs[i], OR_TT, 0);
        wait_done("timing");
        check_result("timing", OR_TT, vs);

        // Reset during vector 5, with start held alongside reset
        pulse_start("rstmid");
        for (int i = 0; i < 5; i++) apply_vec(3'(i), OR_TT, 0);
        wait_ready("rstmid");
        vec = 3'd5; f_in = OR_TT[5]; vec_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vec_valid = 1'b0;
        applied++;
        #2 rst = 1'b1;
        start = 1'b1;
        #1 chk_all_zero("rstmid.async");
        @(posedge clk);
        @(negedge clk);
        chk("rstmid.start_vs_rst", 32'(busy), 0);
        start = 1'b0;
        rst   = 1'b0;
        for (int i = 0; i < NV; i++) vs[i] = 3'(i);
        do_run("rstmid.fresh", AND_TT, vs, 0);

        // Duplicate vector 0, vector 7 never applied
        vs[0] = 3'd0;
        for (int i = 1; i < NV; i++) vs[i] = 3'(i - 1);
        do_run("dup", AND_TT, vs, 1);

        // start during a run and vec_valid held through SETTLE
        pulse_start("midstart");
        wait_ready("midstart");
        vec = 3'd3; f_in = OR_TT[3]; vec_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        applied++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midstart.busy", 32'(busy), 1);
        @(negedge clk);
        vec_valid = 1'b0;
        wait_ready("midstart");
        chk("midstart.err", 32'(err_count), 1);
        vs[0] = 3'd3; vs[1] = 3'd0; vs[2] = 3'd1; vs[3] = 3'd2;
        vs[4] = 3'd4; vs[5] = 3'd5; vs[6] = 3'd6; vs[7] = 3'd7;
        for (int i = 1; i < NV - 1; i++) apply_vec(vs[i], OR_TT, 0);
        chk("midstart.not_done", 32'(done), 0);
        apply_vec(vs[NV-1], OR_TT, 0);
        wait_done("midstart");
        check_result("midstart", OR_TT, vs);

        // Random gates and random vector lists
        for (int r = 0; r < 16; r++) begin
            rtt = 8'($urandom);
            if (r == 0) rtt = EXP;
            for (int i = 0; i < NV; i++) vs[i] = 3'($urandom_range(0, NV - 1));
            if (r == 1) for (int i = 0; i < NV; i++) vs[i] = 3'(NV - 1 - i);
            do_run($sformatf("rand%0d", r), rtt, vs, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Response end of the exhaustive-vector gate test flow: the stimulus side drives an input vector to a combinational gate under test.
- This block consumes each applied vector, waits a settle interval, samples the gate output F and compares it with a parameterised expected truth table.
- It accumulates mismatches and reports pass/fail once all 2^N_IN vectors have been checked.
- It sits beside the gate in the lab top level and replaces manual waveform inspection.

Parameters:
N_IN, 3, number of gate inputs; the vector space is 2^N_IN.
EXP_TT, 8'b0000_0000, expected truth table, width 2^N_IN; bit k = expected F for vector k.
SETTLE, 2, clock cycles to wait between accepting a vector and sampling F; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse, begins a check run
vec_valid  in  1  stimulus side presents a vector
vec  in  N_IN  vector currently applied to the gate (P,Q,R order, P = MSB)
vec_ready  out  1  checker can accept a vector
f_in  in  1  gate output F
busy  out  1  run in progress
done  out  1  run complete; held until next start
pass  out  1  valid when done; 1 = zero mismatches
err_count  out  N_IN+1  mismatch count, saturating at 2^N_IN
first_err_vec  out  N_IN  vector of the first mismatch
first_err_valid  out  1  first_err_vec holds a captured value

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; the internal accept counter and settle counter are 0.
- FSM states and transitions:
  - IDLE -> ARM on start.
  - ARM: vec_ready=1. A vector is accepted when vec_valid&&vec_ready; it is latched to vec_q and the block moves to SETTLE.
  - SETTLE: vec_ready=0. Counts SETTLE cycles, then moves to SAMPLE.
  - SAMPLE (1 cycle): compare f_in with EXP_TT[vec_q].
    - On mismatch: increment err_count (saturating). If first_err_valid=0, capture first_err_vec=vec_q and set first_err_valid=1.
    - Increment the accept count. If it reaches 2^N_IN, go to DONE; otherwise go to ARM.
  - DONE: done=1, pass=(err_count==0), busy=0. Stays until start, which clears err_count, first_err_*, done and pass, then goes to ARM.
- busy=1 in ARM, SETTLE and SAMPLE.
- Latency: the sample occurs exactly SETTLE+1 cycles after the accepting edge; the next vec_ready assertion follows one cycle after SAMPLE.
- Boundary conditions:
  - start while busy: ignored.
  - vec_valid while not ready: ignored; the stimulus side must hold the vector.
  - Repeated vectors are checked and counted like any other; the run ends after 2^N_IN accepts regardless of duplicates.
  - f_in must stay stable from the accepting edge through SAMPLE; the checker samples only in SAMPLE.
  - Reset mid-run: immediate return to IDLE; all results cleared.
  - start coinciding with rst: rst wins.

Optional Feature:
TT_COVERAGE_EN:
- Defined: add a 2^N_IN-bit covered bitmap, set per accepted vector and cleared on start.
  - Add output cov_missing (1 bit), valid in DONE: 1 if any bitmap bit is 0.
  - pass becomes (err_count==0)&&!cov_missing.
- Undefined: no bitmap, no cov_missing port; pass depends on err_count alone.

Decomposition:
- Package tt_check_pkg holds:
  - the state enum (IDLE, ARM, SETTLE, SAMPLE, DONE);
  - the localparam for vector count 2^N_IN;
  - the settle counter width (4 bits).
- One sub-module is natural: settle_timer. It takes a load pulse and count value and produces an expire pulse; the FSM instantiates it.

Test Plan:
- EXP_TT=8'b1000_0000 (AND3), correct AND gate, vectors 0..7 in order -> done after 8 accepts, pass=1, err_count=0, first_err_valid=0.
- Same EXP_TT, gate replaced by OR3 -> err_count=6, first_err_vec=3'b001, pass=0.
- SETTLE=3, check vec_ready and the sample point -> sample exactly 4 cycles after the accepting edge; vec_ready low in SETTLE/SAMPLE.
- Assert rst during vector 5 -> all outputs 0 asynchronously. A new start plus 8 vectors -> fresh result with no carried-over errors.
- Vectors 0,0,1..6 (7 missing) with a correct gate -> done after 8 accepts. Without TT_COVERAGE_EN: pass=1. With TT_COVERAGE_EN: cov_missing=1, pass=0.
- start pulsed mid-run and vec_valid held during SETTLE -> no restart, no extra accept, err_count unchanged.
